// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - register map, status bit positions and transmit FSM states for io_uart
package io_uart_pkg;

  // Register word indices, taken from byte address bits [4:2]
  localparam logic [2:0] REG_TXDATA  = 3'd0;  // offset 0x00
  localparam logic [2:0] REG_STATUS  = 3'd1;  // offset 0x04
  localparam logic [2:0] REG_BAUDDIV = 3'd2;  // offset 0x08

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int IO_SEL_BIT = 22;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/io_uart_if.sv
// rtl/io_uart_if.sv - memory-stage IO port between the core and the UART
interface io_uart_if;
  logic [31:0] IO_memAddr;
  logic [31:0] IO_memWData;
  logic        IO_memWr;
  logic [31:0] IO_memRData;

  modport master (
    output IO_memAddr, IO_memWData, IO_memWr,
    input  IO_memRData
  );

  modport slave (
    input  IO_memAddr, IO_memWData, IO_memWr,
    output IO_memRData
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX byte FIFO with extra-bit pointers
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer MSBs differ only when the writer has lapped the reader
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/io_uart.sv
// rtl/io_uart.sv - memory-mapped 8N1 UART transmitter with TX FIFO and combinational register reads
module io_uart
  import io_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic     clk_i,
  input  logic     reset_i,
  io_uart_if.slave bus,
  output logic     tx_o
);
  localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ_HZ / BAUD);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [2:0]    reg_idx;
  logic          wr_tx, wr_status, wr_baud;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [15:0]   baud_div;
  logic [31:0]   rdata;

  tx_state_t   state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shift, shift_nx;
  logic        tx_nx;
  logic        bit_end;

  logic unused_bits;
  assign unused_bits = ^{bus.IO_memAddr[31:23], bus.IO_memAddr[21:5],
                         bus.IO_memAddr[1:0], bus.IO_memWData[31:16]};

  assign sel       = bus.IO_memAddr[IO_SEL_BIT];
  assign reg_idx   = bus.IO_memAddr[4:2];
  assign wr_tx     = sel && bus.IO_memWr && (reg_idx == REG_TXDATA);
  assign wr_status = sel && bus.IO_memWr && (reg_idx == REG_STATUS);
  assign wr_baud   = sel && bus.IO_memWr && (reg_idx == REG_BAUDDIV);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
  assign fifo_push = wr_tx && (!fifo_full || fifo_pop);

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .push      (fifo_push),
    .push_data (bus.IO_memWData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overflow <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      if (wr_tx && fifo_full && !fifo_pop)        overflow <= 1'b1;
      else if (wr_status && bus.IO_memWData[3])   overflow <= 1'b0;
      if (wr_baud)
        baud_div <= (bus.IO_memWData[15:0] == 16'd0) ? 16'd1 : bus.IO_memWData[15:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: begin
          rdata[ST_FULL]             = fifo_full;
          rdata[ST_EMPTY]            = fifo_empty;
          rdata[ST_BUSY]             = (state != TX_IDLE);
          rdata[ST_OVERFLOW]         = overflow;
          rdata[ST_COUNT_LSB +: 5]   = 5'(fifo_count);
        end
        REG_BAUDDIV: rdata[15:0] = baud_div;
        default: ;
      endcase
    end
  end
  assign bus.IO_memRData = rdata;

  assign bit_end = (cnt == 16'd0);

  always_comb begin
    state_nx   = state;
    cnt_nx     = bit_end ? cnt : cnt - 16'd1;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    fifo_pop   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_nx = fifo_dout;
          state_nx = TX_START;
          cnt_nx   = baud_div - 16'd1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_nx   = TX_DATA;
          bit_idx_nx = 3'd0;
          cnt_nx     = baud_div - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_nx = {1'b0, shift[7:1]};
          cnt_nx   = baud_div - 16'd1;
          if (bit_idx == 3'd7) state_nx   = TX_STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_nx = fifo_dout;
            state_nx = TX_START;
            cnt_nx   = baud_div - 16'd1;
          end else begin
            state_nx = TX_IDLE;
          end
        end
      end
      default: state_nx = TX_IDLE;
    endcase

    // Line level is registered from the next state so it lines up with the state register
    case (state_nx)
      TX_START: tx_nx = 1'b0;
      TX_DATA:  tx_nx = shift_nx[0];
      default:  tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      tx_o    <= tx_nx;
    end
  end
endmodule

// File: tb/tb_io_uart.sv
// tb/tb_io_uart.sv - self-checking bench for io_uart with a per-cycle line-level model
module tb_io_uart;
  localparam logic [31:0] TX_A     = 32'h0040_0000;
  localparam logic [31:0] STATUS_A = 32'h0040_0004;
  localparam logic [31:0] BAUD_A   = 32'h0040_0008;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  io_uart_if bus();

  io_uart dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus),
    .tx_o    (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queued bytes, and the expected line level for every upcoming cycle
  logic [7:0]  fq[$];
  bit          lv_q[$];
  logic        m_ovf  = 1'b0;
  logic [15:0] m_baud = 16'd434;
  bit          chk_en = 1'b0;
  logic [7:0]  m_byte;
  bit          m_lvl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      lv_q.delete();
      m_ovf  = 1'b0;
      m_baud = 16'd434;
    end else begin
      if (lv_q.size() != 0) lv_q.delete(0);
      if (lv_q.size() == 0 && fq.size() != 0) begin
        m_byte = fq.pop_front();
        for (int k = 0; k < 10; k++) begin
          m_lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_byte[k-1];
          for (int c = 0; c < int'(m_baud); c++) lv_q.push_back(m_lvl);
        end
      end
      if (bus.IO_memWr && bus.IO_memAddr[22]) begin
        case (bus.IO_memAddr[4:2])
          3'd0: if (fq.size() < 16) fq.push_back(bus.IO_memWData[7:0]); else m_ovf = 1'b1;
          3'd1: if (bus.IO_memWData[3]) m_ovf = 1'b0;
          3'd2: m_baud = (bus.IO_memWData[15:0] == 16'd0) ? 16'd1 : bus.IO_memWData[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[22]) begin
      case (a[4:2])
        3'd1: begin
          r[0]    = (fq.size() == 16);
          r[1]    = (fq.size() == 0);
          r[2]    = (lv_q.size() != 0);
          r[3]    = m_ovf;
          r[12:8] = 5'(fq.size());
        end
        3'd2: r[15:0] = m_baud;
        default: ;
      endcase
    end
    return r;
  endfunction

  logic exp_tx;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_tx = (lv_q.size() != 0) ? lv_q[0] : 1'b1;
      chk("tx_line", 64'(tx), 64'(exp_tx));
      chk("rdata", 64'(bus.IO_memRData), 64'(exp_read(bus.IO_memAddr)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.IO_memAddr  = a;
    bus.IO_memWData = d;
    bus.IO_memWr    = 1'b1;
    @(posedge clk);
    #1;
    bus.IO_memWr    = 1'b0;
    bus.IO_memAddr  = STATUS_A;
    bus.IO_memWData = '0;
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.IO_memAddr = a;
    #1;
    chk(name, 64'(bus.IO_memRData), 64'(exp));
    bus.IO_memAddr = STATUS_A;
    #1;
  endtask

  logic [39:0] cap;
  int          busy_cnt;

  task automatic capture40();
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cap[i] = tx;
      if (bus.IO_memRData[2]) busy_cnt++;
      step(1);
    end
  endtask

  initial begin
    bus.IO_memAddr  = STATUS_A;
    bus.IO_memWData = '0;
    bus.IO_memWr    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    chk("reset_tx", 64'(tx), 64'd1);
    rd(STATUS_A, 32'h0000_0002, "reset_status");
    rd(BAUD_A, 32'd434, "reset_baud");

    // Single frame, divider 4
    wr(BAUD_A, 32'd4);
    wr(TX_A, 32'h55);
    chk("busy_on_pop_cycle", 64'(bus.IO_memRData[2]), 64'd0);
    step(1);
    capture40();
    chk("frame_55", 64'(cap), 64'h00_F0F0F0F0F0);
    chk("busy_cycles_55", 64'(busy_cnt), 64'd40);
    rd(STATUS_A, 32'h0000_0002, "status_after_55");

    // Two back-to-back frames, divider 2
    wr(BAUD_A, 32'd2);
    wr(TX_A, 32'hA5);
    wr(TX_A, 32'h3C);
    capture40();
    chk("frames_a5_3c", 64'(cap), 64'h00_C3FC0F30CC);
    chk("busy_cycles_2f", 64'(busy_cnt), 64'd40);
    rd(STATUS_A, 32'h0000_0002, "status_after_2f");

    // Unmapped offset and deselected block
    wr(32'h0040_0010, 32'h41);
    wr(32'h0000_0000, 32'h41);
    step(10);
    chk("no_tx_unmapped", 64'(tx), 64'd1);
    rd(STATUS_A, 32'h0000_0002, "status_unmapped");
    rd(32'h0040_0010, 32'h0, "read_off10");
    rd(32'h0000_0000, 32'h0, "read_unsel");
    wr(BAUD_A, 32'd0);
    rd(BAUD_A, 32'd1, "baud_zero_is_one");

    // Overflow: 1 popped, 16 queued, 18th dropped
    wr(BAUD_A, 32'd1000);
    for (int i = 0; i < 18; i++) wr(TX_A, 32'(8'h10 + i));
    rd(STATUS_A, 32'h0000_100D, "status_overflow");
    wr(STATUS_A, 32'h8);
    rd(STATUS_A, 32'h0000_1005, "status_ovf_cleared");
    chk("tx_start_bit_1000", 64'(tx), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_async_start", 64'(tx), 64'd1);
    step(2);
    rst_n = 1'b1;
    step(1);
    rd(STATUS_A, 32'h0000_0002, "status_after_reset1");

    // Reset during data bit 3
    wr(BAUD_A, 32'd4);
    wr(TX_A, 32'h00);
    step(18);
    chk("data_bit3_low", 64'(tx), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_async_data", 64'(tx), 64'd1);
    step(2);
    rst_n = 1'b1;
    step(1);
    rd(STATUS_A, 32'h0000_0002, "status_after_reset2");
    rd(BAUD_A, 32'd434, "baud_after_reset2");
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
